mul_and_reduce_pipe: RTL and testbench
======================================

Name: mul_and_reduce_pipe

Overview:
Pipelined Montgomery modular multiplier for the NTT/polynomial datapath. Computes op1*op2*R^-1 mod Q with R = 2^MULTIPLIER_WIDTH, using precomputed QINV = -Q^-1 mod R. It accepts one operand pair per clock and returns a fully reduced coefficient after a fixed latency, with a one-cycle done pulse per operation.

Parameters:
COEFF_WIDTH, 31, width of operands and result (unsigned coefficient bits).
MULTIPLIER_WIDTH, 32, Montgomery radix exponent; R = 2^MULTIPLIER_WIDTH.
PARAM_Q, 856145921, odd modulus; must satisfy Q < 2^COEFF_WIDTH.
PARAM_QINV, 587710463, equal to -Q^-1 mod 2^MULTIPLIER_WIDTH (0x2307BFFF for Q = 0x3307C001).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous reset, active-low (rst = 0 resets on the next clk edge).
start  in  1  operand-valid strobe; op1 and op2 are sampled on any edge where start = 1 and rst = 1.
op1  in  COEFF_WIDTH  multiplicand, unsigned, must be < Q.
op2  in  COEFF_WIDTH  multiplier, unsigned, must be < Q.
result  out  COEFF_WIDTH  Montgomery product, valid when done = 1.
busy  out  1  high while at least one accepted operation is still in the pipeline.
done  out  1  one-cycle pulse per accepted operation, aligned with its result.

Behaviour:
- Reset (rst = 0 at a clk edge): all pipeline valid bits, data registers, result, busy and done go to 0. Operations already in flight are discarded. start is ignored while rst = 0.
- Ports are treated as unsigned, even if the driver declares them signed.
- Pipeline has 4 register stages and no stalls. An operation accepted at edge k has done = 1 and its result valid after edge k+4.
- S1: T = op1*op2, a 2*COEFF_WIDTH-bit product; register T and valid.
- S2: m = (T mod R)*QINV mod R, a MULTIPLIER_WIDTH-bit value; forward T.
- S3: U = T + m*Q, computed at full width of at least 2*MULTIPLIER_WIDTH+1 bits, so no overflow occurs.
- S4: t = U >> MULTIPLIER_WIDTH, which is exact because U mod R = 0. If t >= Q then result = t - Q, else result = t. Register result and set done to the stage-4 valid bit.
- result < Q and result ≡ op1*op2*2^-32 (mod Q) for in-range inputs.
- Out-of-range inputs (>= Q) still give a result congruent mod Q, but the result is not guaranteed to be < Q.
- Throughput: one operation per cycle. If start is held high continuously, done stays high every cycle from edge 4 onward, one pulse per operation.
- done is 0 in any cycle whose stage-4 slot is empty.
- result holds its last value when done = 0.
- busy = OR of the S1..S3 valid bits plus the pending-start condition, registered so that busy = 1 from the edge after acceptance until the edge at which that operation's done asserts. busy = 0 when the pipeline is empty.
- Back-to-back operations, gaps in start, and a start coinciding with a done all occur independently. No operation is lost or duplicated.
- rst taking effect mid-operation clears the pipeline. The first done after reset release comes only from a start sampled after release.

Test Plan:
- Hold rst = 0 for 3 cycles with start = 1 -> result = 0, busy = 0, done = 0 throughout. Release rst -> first done exactly 4 edges after the first sampled start.
- Identity: op1 = 14237691 (2^32 mod Q), op2 = 12345 -> result = 12345 with a single done pulse at latency 4. Repeat with op2 = 856145920 -> result = 856145920.
- Zero and fixed point: op1 = 0, op2 = 23526262 -> result = 0. op1 = op2 = 14237691 -> result = 14237691.
- Random in-range streaming: 1000 pairs with start = 1 every cycle, including op1 = 35425252, op2 = 23526262 -> each result equals the reference (op1*op2*inverse(2^32) mod Q) in order, with done high continuously after fill.
- Sparse start (pattern 1,0,0,1,1,0) -> done reproduces the same pattern delayed by 4. busy is high only while operations are in flight.
- Assert rst = 0 two cycles after a start -> no done for that operation, all outputs 0. A new start after release completes normally.

Source files
------------

// File: rtl/mul_and_reduce_pipe.sv
// Montgomery multiplier: result = op1*op2*2^-MULTIPLIER_WIDTH mod Q, fully reduced for inputs < Q.
// Latency 4 edges from the sampled start to done; one op per cycle, no stalls and no backpressure.
module mul_and_reduce_pipe #(
    parameter int COEFF_WIDTH      = 31,
    parameter int MULTIPLIER_WIDTH = 32,
    parameter logic [COEFF_WIDTH-1:0]      PARAM_Q    = 31'd856145921,
    parameter logic [MULTIPLIER_WIDTH-1:0] PARAM_QINV = 32'd587710463
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COEFF_WIDTH-1:0] op1,
    input  logic [COEFF_WIDTH-1:0] op2,
    output logic [COEFF_WIDTH-1:0] result,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = COEFF_WIDTH;
    localparam int MW = MULTIPLIER_WIDTH;
    localparam int PW = 2 * CW;
    localparam int UW = 2 * MW + 1;

    localparam logic [UW-1:0] Q_U = {{(UW - CW){1'b0}}, PARAM_Q};
    localparam logic [MW:0]   Q_T = {{(MW + 1 - CW){1'b0}}, PARAM_Q};

    logic          v0, v1, v2, v3;
    logic [CW-1:0] a0, b0;
    logic [PW-1:0] t1, t2;
    logic [MW-1:0] m2;
    logic [MW:0]   u3;

    logic [PW-1:0] prod;
    logic [MW-1:0] m_next;
    logic [UW-1:0] u_full;
    logic [MW:0]   u_hi;
    logic [MW:0]   t_diff;
    logic [CW-1:0] t_red;

    // U is a multiple of R by construction, so its low half is discarded unseen.
    always_comb begin
        prod   = {{CW{1'b0}}, a0} * {{CW{1'b0}}, b0};
        m_next = t1[MW-1:0] * PARAM_QINV;
        u_full = {{(UW - PW){1'b0}}, t2} + {{(UW - MW){1'b0}}, m2} * Q_U;
        u_hi   = u_full[UW-1:MW];
        t_diff = u3 - Q_T;
        t_red  = (u3 >= Q_T) ? t_diff[CW-1:0] : u3[CW-1:0];
    end

    logic unused_bits;
    assign unused_bits = ^{u_full[MW-1:0], t_diff[MW:CW]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            v0     <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            a0     <= '0;
            b0     <= '0;
            t1     <= '0;
            t2     <= '0;
            m2     <= '0;
            u3     <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            v0 <= start;
            if (start) begin
                a0 <= op1;
                b0 <= op2;
            end
            v1   <= v0;
            t1   <= prod;
            v2   <= v1;
            t2   <= t1;
            m2   <= m_next;
            v3   <= v2;
            u3   <= u_hi;
            done <= v3;
            if (v3) begin
                result <= t_red;
            end
            // Drops at the edge where the youngest op reaches done.
            busy <= start | v0 | v1 | v2;
        end
    end

endmodule

// File: tb/tb_mul_and_reduce_pipe.sv
// Bench for mul_and_reduce_pipe: constant vector table, hand sequences and random streams
// checked cycle by cycle against a repeated-halving Montgomery reference.
module tb_mul_and_reduce_pipe;

    localparam logic [63:0] Q    = 64'd856145921;
    localparam logic [30:0] RMOD = 31'd14237691;

    logic        clk;
    logic        rst;
    logic        start;
    logic [30:0] op1;
    logic [30:0] op2;
    logic [30:0] result;
    logic        busy;
    logic        done;

    mul_and_reduce_pipe dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op1    (op1),
        .op2    (op2),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned acc_edge;
        logic [30:0] val;
    } op_t;

    typedef struct {
        logic [30:0] a;
        logic [30:0] b;
        logic [30:0] exp;
    } vec_t;

    op_t         pend[$];
    int unsigned ecount;
    logic [30:0] exp_res;
    int          compared;
    int          mismatched;

    // x * 2^-32 mod Q by halving modulo Q 32 times.
    function automatic logic [30:0] mont_ref(input logic [30:0] a, input logic [30:0] b);
        logic [63:0] x;
        x = ({33'd0, a} * {33'd0, b}) % Q;
        for (int i = 0; i < 32; i++) begin
            x = x[0] ? ((x + Q) >> 1) : (x >> 1);
        end
        return x[30:0];
    endfunction

    function automatic logic [30:0] rnd_coeff();
        return 31'($urandom_range(0, 32'(Q - 64'd1)));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // One clock: drive inputs, update the reference at the edge, check outputs mid-cycle.
    task automatic step(input logic r, input logic s, input logic [30:0] a, input logic [30:0] b,
                        input logic [30:0] exp);
        op_t e;
        logic exp_done;
        rst   = r;
        start = s;
        op1   = a;
        op2   = b;
        @(posedge clk);
        ecount++;
        if (!r) begin
            pend.delete();
            exp_res = '0;
        end else if (s) begin
            e.acc_edge = ecount;
            e.val      = exp;
            pend.push_back(e);
        end
        @(negedge clk);
        exp_done = (pend.size() > 0) && (pend[0].acc_edge + 4 == ecount);
        if (exp_done) begin
            exp_res = pend[0].val;
            void'(pend.pop_front());
        end
        chk("done", {31'd0, done}, {31'd0, exp_done});
        chk("result", {1'b0, result}, {1'b0, exp_res});
        chk("busy", {31'd0, busy}, {31'd0, logic'(pend.size() > 0)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, rnd_coeff(), rnd_coeff(), '0);
    endtask

    task automatic go(input logic [30:0] a, input logic [30:0] b);
        step(1'b1, 1'b1, a, b, mont_ref(a, b));
    endtask

    vec_t vecs[6];
    logic pat[6];
    logic [30:0] ra, rb;

    initial begin
        compared   = 0;
        mismatched = 0;
        ecount     = 0;
        exp_res    = '0;
        rst        = 1'b0;
        start      = 1'b1;
        op1        = '0;
        op2        = '0;

        vecs[0] = '{a: RMOD,  b: 31'd12345,     exp: 31'd12345};
        vecs[1] = '{a: RMOD,  b: 31'd856145920, exp: 31'd856145920};
        vecs[2] = '{a: 31'd0, b: 31'd23526262,  exp: 31'd0};
        vecs[3] = '{a: RMOD,  b: RMOD,          exp: RMOD};
        vecs[4] = '{a: 31'd1, b: RMOD,          exp: 31'd1};
        vecs[5] = '{a: 31'd23526262, b: 31'd0,  exp: 31'd0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset held with start asserted: nothing may be accepted.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd_coeff(), rnd_coeff(), '0);
        go(31'd777, 31'd999);
        idle(5);

        // Constant vectors, each isolated so its done is a single pulse.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
            idle(5);
        end
        // Same vectors back to back.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
        idle(5);

        // Sparse start pattern, twice.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 6; i++) begin
                if (pat[i]) go(rnd_coeff(), rnd_coeff());
                else idle(1);
            end
        idle(6);

        // Reset two cycles after a start kills that op.
        go(rnd_coeff(), rnd_coeff());
        idle(1);
        step(1'b0, 1'b0, '0, '0, '0);
        idle(6);
        go(31'd35425252, 31'd23526262);
        idle(5);

        // Reset with a full pipeline.
        for (int i = 0; i < 3; i++) go(rnd_coeff(), rnd_coeff());
        step(1'b0, 1'b1, rnd_coeff(), rnd_coeff(), '0);
        go(rnd_coeff(), rnd_coeff());
        idle(5);

        // Continuous stream.
        go(31'd35425252, 31'd23526262);
        for (int i = 1; i < 1000; i++) begin
            ra = rnd_coeff();
            rb = rnd_coeff();
            if (i % 97 == 0) ra = 31'(Q - 64'd1);
            go(ra, rb);
        end
        idle(6);

        // Random gaps, starts coinciding with dones.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0) go(rnd_coeff(), rnd_coeff());
            else idle(1);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
